// File: rtl/core_pkg.sv
// Shared types and constants for the multi-cycle RV32I control path.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package core_pkg;

    typedef enum logic [2:0] {
        BOOT,
        FETCH,
        DECODE,
        EXECUTE,
        MEM,
        WRITEBACK,
        HALT
    } state_t;

    localparam logic [1:0] CAUSE_NONE     = 2'd0;
    localparam logic [1:0] CAUSE_ILLEGAL  = 2'd1;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'd2;
    localparam logic [1:0] CAUSE_MISALIGN = 2'd3;

    localparam logic [31:0] INSTR_BYTES = 32'd4;

endpackage

// File: rtl/ack_watchdog.sv
// Counts consecutive wait cycles without ack and flags the final unanswered one.
// Latency: expired is combinational from the count and the current ack.
// Backpressure: none; an ack on the limit cycle suppresses expired.
module ack_watchdog #(
    parameter int TIMEOUT = 16
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clear,
    input  logic waiting,
    input  logic ack,
    output logic expired
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt;

    // cnt equals the number of wait cycles already spent before this one
    assign expired = waiting && !ack && (cnt == LIMIT);

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (waiting && !ack && !expired) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle RV32I control FSM: owns PC and IR, sequences fetch/decode/execute/mem/writeback.
// Latency: 4 cycles per ALU/branch instruction, 5 for load/store, plus one per ack wait cycle.
// Backpressure: imem/dmem req held until ack; watchdog halts the core if an ack never arrives.
module multicycle_sequencer
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 16
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] instr_o,
    input  logic        dec_illegal_i,
    input  logic        dec_mem_rd_i,
    input  logic        dec_mem_wr_i,
    input  logic        dec_reg_wr_i,
    input  logic        dec_jump_i,
    input  logic        br_taken_i,
    input  logic [31:0] target_i,
    output logic [31:0] pc_o,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    input  logic        dmem_ack_i,
    output logic        alu_en_o,
    output logic        rf_wr_en_o,
    output logic        retire_o,
    output logic        halted_o,
    output logic [1:0]  halt_cause_o
);

    state_t      state_q, state_n;
    logic [31:0] pc_q, pc_n;
    logic [31:0] instr_q, instr_n;
    logic [1:0]  cause_q, cause_n;

    logic wd_clear, wd_waiting, wd_ack, wd_expired;
    logic redirect;

    // Watchdog controls derive from the registered state only, keeping the
    // expired -> next-state path free of combinational loops.
    assign wd_waiting = (state_q == FETCH) || (state_q == MEM);
    assign wd_ack     = (state_q == FETCH) ? imem_ack_i : dmem_ack_i;
    assign wd_clear   = (state_n != state_q) && ((state_n == FETCH) || (state_n == MEM));
    assign redirect   = dec_jump_i || br_taken_i;

    ack_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .clear   (wd_clear),
        .waiting (wd_waiting),
        .ack     (wd_ack),
        .expired (wd_expired)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            cause_q <= CAUSE_NONE;
        end else begin
            state_q <= state_n;
            pc_q    <= pc_n;
            instr_q <= instr_n;
            cause_q <= cause_n;
        end
    end

    always_comb begin
        state_n    = state_q;
        pc_n       = pc_q;
        instr_n    = instr_q;
        cause_n    = cause_q;
        imem_req_o = 1'b0;
        dmem_req_o = 1'b0;
        dmem_we_o  = 1'b0;
        alu_en_o   = 1'b0;
        rf_wr_en_o = 1'b0;
        retire_o   = 1'b0;

        case (state_q)
            BOOT: begin
                state_n = FETCH;
            end
            FETCH: begin
                imem_req_o = 1'b1;
                if (imem_ack_i) begin
                    instr_n = imem_rdata_i;
                    state_n = DECODE;
                end else if (wd_expired) begin
                    cause_n = CAUSE_TIMEOUT;
                    state_n = HALT;
                end
            end
            DECODE: begin
                if (dec_illegal_i) begin
                    cause_n = CAUSE_ILLEGAL;
                    state_n = HALT;
                end else begin
                    state_n = EXECUTE;
                end
            end
            EXECUTE: begin
                alu_en_o = 1'b1;
                state_n  = (dec_mem_rd_i || dec_mem_wr_i) ? MEM : WRITEBACK;
            end
            MEM: begin
                dmem_req_o = 1'b1;
                dmem_we_o  = dec_mem_wr_i;
                if (dmem_ack_i) begin
                    state_n = WRITEBACK;
                end else if (wd_expired) begin
                    cause_n = CAUSE_TIMEOUT;
                    state_n = HALT;
                end
            end
            WRITEBACK: begin
                // A misaligned redirect must not commit any architectural state
                if (redirect && (target_i[1:0] != 2'b00)) begin
                    cause_n = CAUSE_MISALIGN;
                    state_n = HALT;
                end else begin
                    rf_wr_en_o = dec_reg_wr_i;
                    retire_o   = 1'b1;
                    pc_n       = redirect ? target_i : (pc_q + INSTR_BYTES);
                    state_n    = FETCH;
                end
            end
            HALT: begin
                state_n = HALT;
            end
            default: begin
                state_n = HALT;
            end
        endcase
    end

    assign imem_addr_o  = pc_q;
    assign pc_o         = pc_q;
    assign instr_o      = instr_q;
    assign halted_o     = (state_q == HALT);
    assign halt_cause_o = cause_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer with a retire-expectation scoreboard.
module tb_multicycle_sequencer;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam int          TO     = 16;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] instr_o;
    logic        dec_illegal_i;
    logic        dec_mem_rd_i;
    logic        dec_mem_wr_i;
    logic        dec_reg_wr_i;
    logic        dec_jump_i;
    logic        br_taken_i;
    logic [31:0] target_i;
    logic [31:0] pc_o;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic        dmem_ack_i;
    logic        alu_en_o;
    logic        rf_wr_en_o;
    logic        retire_o;
    logic        halted_o;
    logic [1:0]  halt_cause_o;

    multicycle_sequencer #(
        .RESET_PC (RST_PC),
        .TIMEOUT  (TO)
    ) dut (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ack_i    (imem_ack_i),
        .imem_rdata_i  (imem_rdata_i),
        .instr_o       (instr_o),
        .dec_illegal_i (dec_illegal_i),
        .dec_mem_rd_i  (dec_mem_rd_i),
        .dec_mem_wr_i  (dec_mem_wr_i),
        .dec_reg_wr_i  (dec_reg_wr_i),
        .dec_jump_i    (dec_jump_i),
        .br_taken_i    (br_taken_i),
        .target_i      (target_i),
        .pc_o          (pc_o),
        .dmem_req_o    (dmem_req_o),
        .dmem_we_o     (dmem_we_o),
        .dmem_ack_i    (dmem_ack_i),
        .alu_en_o      (alu_en_o),
        .rf_wr_en_o    (rf_wr_en_o),
        .retire_o      (retire_o),
        .halted_o      (halted_o),
        .halt_cause_o  (halt_cause_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [31:0] pc_after;
        logic        rf_wr;
        logic        retire;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] model_pc;

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk1(input string tag, input logic got, input logic exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        imem_ack_i    = 1'b0;
        imem_rdata_i  = 32'h0;
        dmem_ack_i    = 1'b0;
        dec_illegal_i = 1'b0;
        dec_mem_rd_i  = 1'b0;
        dec_mem_wr_i  = 1'b0;
        dec_reg_wr_i  = 1'b0;
        dec_jump_i    = 1'b0;
        br_taken_i    = 1'b0;
        target_i      = 32'h0;
    endtask

    // Leaves the bench in the first FETCH cycle, inputs settled.
    task automatic do_reset();
        rst_n_i = 1'b0;
        clear_inputs();
        cyc();
        settle();
        chk1 ("rst.halted",  halted_o,   1'b0);
        chk1 ("rst.ireq",    imem_req_o, 1'b0);
        chk1 ("rst.dreq",    dmem_req_o, 1'b0);
        chk1 ("rst.dwe",     dmem_we_o,  1'b0);
        chk1 ("rst.alu",     alu_en_o,   1'b0);
        chk1 ("rst.rfwr",    rf_wr_en_o, 1'b0);
        chk1 ("rst.retire",  retire_o,   1'b0);
        chk32("rst.pc",      pc_o,        RST_PC);
        chk32("rst.iaddr",   imem_addr_o, RST_PC);
        chk32("rst.instr",   instr_o,     32'h0);
        chk32("rst.cause",   {30'd0, halt_cause_o}, 32'd0);
        rst_n_i = 1'b1;
        settle();
        chk1 ("boot.ireq", imem_req_o, 1'b0);
        cyc();
        settle();
        chk1 ("fetch.ireq",  imem_req_o,  1'b1);
        chk32("fetch.iaddr", imem_addr_o, RST_PC);
        model_pc = RST_PC;
    endtask

    // One full instruction: iw imem wait cycles before ack, dw dmem wait cycles.
    task automatic run_instr(input string nm, input int iw, input logic [31:0] word,
                             input logic rd, input logic wr, input logic rw,
                             input logic jmp, input logic br, input logic [31:0] tgt,
                             input int dw);
        exp_t e;
        logic mis;
        mis = (jmp || br) && (tgt[1:0] != 2'b00);
        e.pc_after = mis ? model_pc : ((jmp || br) ? tgt : model_pc + 32'd4);
        e.rf_wr    = rw && !mis;
        e.retire   = !mis;
        sb.push_back(e);

        dec_mem_rd_i = rd;
        dec_mem_wr_i = wr;
        dec_reg_wr_i = rw;
        dec_jump_i   = jmp;
        br_taken_i   = br;
        target_i     = tgt;

        for (int i = 0; i <= iw; i++) begin
            imem_ack_i   = (i == iw);
            imem_rdata_i = (i == iw) ? word : 32'hDEAD_BEEF;
            settle();
            chk1 ({nm, ".ireq"},  imem_req_o,  1'b1);
            chk32({nm, ".iaddr"}, imem_addr_o, model_pc);
            chk1 ({nm, ".dec_alu"}, alu_en_o, 1'b0);
            cyc();
        end
        imem_ack_i   = 1'b0;
        imem_rdata_i = 32'h0;
        settle();
        chk1 ({nm, ".dec_ireq"}, imem_req_o, 1'b0);
        chk32({nm, ".instr"},    instr_o,    word);
        cyc();
        settle();
        chk1 ({nm, ".alu"}, alu_en_o, 1'b1);
        cyc();
        if (rd || wr) begin
            for (int j = 0; j <= dw; j++) begin
                dmem_ack_i = (j == dw);
                settle();
                chk1({nm, ".dreq"}, dmem_req_o, 1'b1);
                chk1({nm, ".dwe"},  dmem_we_o,  wr);
                chk1({nm, ".mem_retire"}, retire_o, 1'b0);
                cyc();
            end
            dmem_ack_i = 1'b0;
        end
        settle();
        e = sb.pop_front();
        chk1({nm, ".retire"}, retire_o,   e.retire);
        chk1({nm, ".rfwr"},   rf_wr_en_o, e.rf_wr);
        chk1({nm, ".wb_dreq"}, dmem_req_o, 1'b0);
        chk1({nm, ".wb_alu"}, alu_en_o,   1'b0);
        chk32({nm, ".wb_instr"}, instr_o, word);
        cyc();
        settle();
        chk32({nm, ".pc_next"}, pc_o,     e.pc_after);
        chk1 ({nm, ".halted"},  halted_o, !e.retire);
        chk1 ({nm, ".post_retire"}, retire_o, 1'b0);
        chk1 ({nm, ".post_rfwr"},   rf_wr_en_o, 1'b0);
        if (e.retire) model_pc = e.pc_after;
        clear_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not reach the summary");
        $fatal(1, "bench time limit expired");
    end

    initial begin
        rst_n_i = 1'b0;
        clear_inputs();
        repeat (3) cyc();
        do_reset();

        // Straight-line execution, loads/stores with waits, redirects
        run_instr("addi",  0,      32'h0010_0093, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   0);
        chk32("addi.next_fetch", imem_addr_o, 32'h0000_0104);
        run_instr("lw",    0,      32'h0000_2103, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   3);
        run_instr("sw",    2,      32'h0020_2023, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   1);
        run_instr("beq",   0,      32'h0000_0063, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h200, 0);
        chk32("beq.next_fetch", imem_addr_o, 32'h0000_0200);
        run_instr("jal",   TO - 1, 32'h0000_00EF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h300, 0);
        run_instr("bnt",   1,      32'h0000_1063, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h400, 0);
        chk32("bnt.next_fetch", imem_addr_o, 32'h0000_0304);
        run_instr("bmis",  0,      32'h0000_0063, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h202, 0);
        chk32("bmis.cause", {30'd0, halt_cause_o}, 32'd3);

        // Halt is sticky and ignores stray acks
        imem_ack_i = 1'b1;
        dmem_ack_i = 1'b1;
        imem_rdata_i = 32'h1234_5678;
        cyc();
        clear_inputs();
        cyc();
        settle();
        chk1 ("halt.sticky", halted_o,   1'b1);
        chk1 ("halt.ireq",   imem_req_o, 1'b0);
        chk32("halt.pc",     pc_o,       32'h0000_0304);
        chk32("halt.instr",  instr_o,    32'h0000_0063);
        chk32("halt.cause",  {30'd0, halt_cause_o}, 32'd3);

        // Fetch never acknowledged
        do_reset();
        for (int i = 0; i < TO; i++) begin
            imem_ack_i = 1'b0;
            settle();
            chk1("to.ireq", imem_req_o, 1'b1);
            cyc();
        end
        settle();
        chk1 ("to.halted", halted_o,   1'b1);
        chk1 ("to.ireq_drop", imem_req_o, 1'b0);
        chk32("to.cause",  {30'd0, halt_cause_o}, 32'd2);
        chk32("to.pc",     pc_o, RST_PC);

        // Illegal opcode
        do_reset();
        imem_ack_i    = 1'b1;
        imem_rdata_i  = 32'hFFFF_FFFF;
        dec_illegal_i = 1'b1;
        cyc();
        imem_ack_i = 1'b0;
        settle();
        chk1("ill.dec_alu", alu_en_o, 1'b0);
        cyc();
        settle();
        chk1 ("ill.halted", halted_o, 1'b1);
        chk1 ("ill.alu",    alu_en_o, 1'b0);
        chk32("ill.cause",  {30'd0, halt_cause_o}, 32'd1);

        // Reset asserted in the middle of a data wait
        do_reset();
        dec_mem_rd_i = 1'b1;
        imem_ack_i   = 1'b1;
        imem_rdata_i = 32'h0000_2183;
        cyc();
        imem_ack_i = 1'b0;
        cyc();
        cyc();
        settle();
        chk1("mrst.dreq0", dmem_req_o, 1'b1);
        cyc();
        settle();
        chk1("mrst.dreq1", dmem_req_o, 1'b1);
        rst_n_i = 1'b0;
        cyc();
        settle();
        chk1 ("mrst.dreq_drop", dmem_req_o, 1'b0);
        chk32("mrst.pc",        pc_o,       RST_PC);
        chk1 ("mrst.halted",    halted_o,   1'b0);
        rst_n_i = 1'b1;
        clear_inputs();
        cyc();
        settle();
        chk1 ("mrst.refetch", imem_req_o,  1'b1);
        chk32("mrst.iaddr",   imem_addr_o, RST_PC);
        model_pc = RST_PC;
        run_instr("addi2", 0, 32'h0010_0113, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 0);

        chk32("sb.drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
